// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
//============================================================================
// Module      : muldiv_unit_pkg
// Description : Shared definitions for the RV32M/RV64M multiply-divide unit.
//               Holds the MD_* funct3 encodings and operand-signedness
//               helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//============================================================================
package muldiv_unit_pkg;

  // funct3 of OP/OP-32 with funct7=0000001
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  // rs1 is interpreted as two's complement
  function automatic logic opSignedA(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is interpreted as two's complement
  function automatic logic opSignedB(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
//============================================================================
// Module      : muldiv_unit_if
// Description : Start/busy/done handshake bundle between the EX stage and
//               the multiply-divide unit.
// Ports       : start_i, op_i, a_i, b_i, rd_i, kill_i  (pipeline -> unit)
//               busy_o, done_o, result_o, rd_o         (unit -> pipeline)
//               master = pipeline side, slave = unit side
// Revision    : 1.0 - initial release
//============================================================================
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic [4:0]      rd_i;
  logic            kill_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_o;

  modport master (
    output start_i, op_i, a_i, b_i, rd_i, kill_i,
    input  busy_o, done_o, result_o, rd_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, rd_i, kill_i,
    output busy_o, done_o, result_o, rd_o
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit_div_step.sv
`default_nettype none
//============================================================================
// Module      : muldiv_unit_div_step
// Description : One combinational restoring-division step. Shifts the next
//               dividend bit into the partial remainder, subtracts the
//               divisor when it fits and reports the quotient bit.
// Ports       : i_remainder   partial remainder (always < divisor)
//               i_dividendMsb next dividend bit to bring down
//               i_divisor     divisor magnitude
//               o_remainder   updated partial remainder
//               o_quotientBit quotient bit produced by this step
// Revision    : 1.0 - initial release
//============================================================================
module muldiv_unit_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_remainder,
  input  logic            i_dividendMsb,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_remainder,
  output logic            o_quotientBit
);

  logic [XLEN:0]   w_shifted;
  logic [XLEN-1:0] w_diff;

  always_comb begin
    w_shifted     = {i_remainder, i_dividendMsb};
    o_quotientBit = (w_shifted >= {1'b0, i_divisor});
    // When the divisor fits, the difference is below the divisor and so
    // fits in XLEN bits; the modulo subtraction below is exact.
    w_diff        = w_shifted[XLEN-1:0] - i_divisor;
    o_remainder   = o_quotientBit ? w_diff : w_shifted[XLEN-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
//============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M/RV64M multiply-divide unit for the EX stage.
//               Shift-add multiply / restoring divide on operand magnitudes,
//               one bit per cycle, with sign correction on completion.
//               Divide-by-zero and signed overflow finish in one cycle, as
//               do multiplies when FAST_MUL is set.
// Ports       : clk    rising-edge clock
//               reset  asynchronous active-low reset
//               bus    muldiv_unit_if.slave handshake bundle
// Revision    : 1.0 - initial release
//============================================================================
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;
  localparam logic [XLEN-1:0] c_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        r_state;
  logic [CW-1:0]     r_count;
  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic              r_neg;
  logic [XLEN-1:0]   r_opnd;    // multiplicand (MUL*) or divisor (DIV*)
  logic [2*XLEN-1:0] r_acc;     // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rdOut;

  logic              w_accept, w_isDiv, w_aSgn, w_bSgn, w_negStart;
  logic              w_divZero, w_ovf, w_fast, w_quick;
  logic [XLEN-1:0]   w_aMag, w_bMag, w_quickRes;
  logic [2*XLEN-1:0] w_fastProd;
  logic [1:0]        w_stateNext;

  // ---------------- start-side decode ----------------
  // kill wins over start; start is ignored while iterating
  assign w_accept = bus.start_i && (r_state != c_CALC) && !bus.kill_i;

  always_comb begin
    w_isDiv    = bus.op_i[2];
    w_aSgn     = opSignedA(bus.op_i) && bus.a_i[XLEN-1];
    w_bSgn     = opSignedB(bus.op_i) && bus.b_i[XLEN-1];
    // the most negative value negates to itself, which is its correct unsigned magnitude
    w_aMag     = w_aSgn ? -bus.a_i : bus.a_i;
    w_bMag     = w_bSgn ? -bus.b_i : bus.b_i;
    // remainder takes the dividend's sign; everything else the product of signs
    w_negStart = (w_isDiv && bus.op_i[1]) ? w_aSgn : (w_aSgn ^ w_bSgn);
    w_divZero  = w_isDiv && (bus.b_i == '0);
    w_ovf      = ((bus.op_i == MD_DIV) || (bus.op_i == MD_REM)) &&
                 (bus.a_i == c_MIN) && (bus.b_i == '1);
    w_fast     = FAST_MUL && !w_isDiv;
    w_quick    = w_divZero || w_ovf || w_fast;
    if (w_divZero)
      w_quickRes = bus.op_i[1] ? bus.a_i : '1;
    else if (w_ovf)
      w_quickRes = bus.op_i[1] ? '0 : bus.a_i;
    else
      w_quickRes = (bus.op_i == MD_MUL) ? w_fastProd[XLEN-1:0] : w_fastProd[2*XLEN-1:XLEN];
  end

  generate
    if (FAST_MUL) begin : g_fastMul
      // low 2*XLEN bits of the sign-extended product are exact for every signedness mix
      assign w_fastProd = {{XLEN{w_aSgn}}, bus.a_i} * {{XLEN{w_bSgn}}, bus.b_i};
    end else begin : g_noFastMul
      assign w_fastProd = '0;
    end
  endgenerate

  // ---------------- iteration datapath ----------------
  logic [XLEN:0]     w_sum;
  logic [XLEN-1:0]   w_remNext, w_quo, w_rem, w_calcRes;
  logic              w_qBit;
  logic [2*XLEN-1:0] w_accNext, w_prod;

  muldiv_unit_div_step #(.XLEN(XLEN)) u_divStep (
    .i_remainder  (r_acc[2*XLEN-1:XLEN]),
    .i_dividendMsb(r_acc[XLEN-1]),
    .i_divisor    (r_opnd),
    .o_remainder  (w_remNext),
    .o_quotientBit(w_qBit)
  );

  always_comb begin
    w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    if (r_op[2])
      w_accNext = {w_remNext, r_acc[XLEN-2:0], w_qBit};
    else
      w_accNext = {w_sum, r_acc[XLEN-1:1]};
    // final-step value, sign corrected; only latched on the last CALC cycle
    w_prod = r_neg ? -w_accNext : w_accNext;
    w_quo  = r_neg ? -w_accNext[XLEN-1:0] : w_accNext[XLEN-1:0];
    w_rem  = r_neg ? -w_accNext[2*XLEN-1:XLEN] : w_accNext[2*XLEN-1:XLEN];
    case (r_op)
      MD_MUL:                       w_calcRes = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_calcRes = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              w_calcRes = w_quo;
      default:                      w_calcRes = w_rem;
    endcase
  end

  // ---------------- control ----------------
  always_comb begin
    w_stateNext = r_state;
    if (bus.kill_i)
      w_stateNext = c_IDLE;
    else begin
      case (r_state)
        c_CALC:  if (r_count == '0) w_stateNext = c_DONE;
        default: w_stateNext = w_accept ? (w_quick ? c_DONE : c_CALC) : c_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= c_IDLE;
      r_count  <= '0;
      r_op     <= '0;
      r_rd     <= '0;
      r_neg    <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_rdOut  <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept) begin
        r_op    <= bus.op_i;
        r_rd    <= bus.rd_i;
        r_neg   <= w_negStart;
        r_count <= CW'(XLEN-1);
        r_opnd  <= w_isDiv ? w_bMag : w_aMag;
        r_acc   <= {{XLEN{1'b0}}, (w_isDiv ? w_aMag : w_bMag)};
        if (w_quick) begin
          r_result <= w_quickRes;
          r_rdOut  <= bus.rd_i;
        end
      end else if ((r_state == c_CALC) && !bus.kill_i) begin
        r_acc   <= w_accNext;
        r_count <= r_count - 1'b1;
        if (r_count == '0) begin
          r_result <= w_calcRes;
          r_rdOut  <= r_rd;
        end
      end
    end
  end

  assign bus.busy_o   = (r_state == c_CALC);
  assign bus.done_o   = (r_state == c_DONE);
  assign bus.result_o = r_result;
  assign bus.rd_o     = r_rdOut;

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply-divide unit occupying the EX stage of the xgriscv pipeline, next to the ALU.
- Accepts one operation at a time via a start/busy/done handshake. The hazard logic stalls ID/EX while busy_o is high.
- Width is parametrised. An optional single-cycle multiplier is selectable by parameter.
- Supports kill for branch/exception flushes.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- FAST_MUL, 0, 1: MUL* ops complete one cycle after start; 0: shift-add, XLEN iterations.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start_i  in  1  start request; sampled only when busy_o=0.
- op_i  in  3  funct3 of OP/OP-32 with funct7=0000001: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a_i  in  XLEN  rs1 value.
- b_i  in  XLEN  rs2 value.
- rd_i  in  5  destination register tag.
- kill_i  in  1  synchronous abort of the in-flight operation.
- busy_o  out  1  operation in progress; start ignored.
- done_o  out  1  one-cycle pulse; result_o/rd_o valid.
- result_o  out  XLEN  result; holds until next done.
- rd_o  out  5  tag of completed operation.

Behaviour:
- Reset (reset=0, async): state=IDLE; busy_o=0, done_o=0, result_o=0, rd_o=0; counter, operand and accumulator registers cleared. Reset mid-operation discards the operation with no done pulse.
- FSM states:
  - IDLE→CALC on start_i when neither special case nor fast-mul applies.
  - IDLE→DONE on start_i when a special case or fast-mul applies.
  - CALC→DONE when the counter reaches 0.
  - DONE→IDLE, or DONE→(CALC|DONE) when start_i is present in DONE.
- busy_o=1 in CALC only. busy_o=0 in IDLE and DONE, so a back-to-back start in the DONE cycle is accepted.
- Start cycle (edge T):
  - Latch op, rd, and operand magnitudes. Signed operands are MUL/MULH a and b, MULHSU a, DIV/REM a and b.
  - Latch result sign: MUL*: sa^sb; DIV: sa^sb; REM: sa.
  - Load counter = XLEN-1.
- CALC, one bit per cycle:
  - Multiply: 2*XLEN shift-add accumulator.
  - Divide: restoring step producing quotient bit and partial remainder.
- Latency: start sampled at edge T; iterative ops give done_o high in the cycle after edge T+XLEN (XLEN+1 cycles). Special/fast ops give done_o high after edge T+1.
- Result selection:
  - MUL: low XLEN of signed-corrected product.
  - MULH/MULHSU/MULHU: high XLEN.
  - DIV(U): quotient; REM(U): remainder.
  - Sign correction is applied by two's-complement negate at the CALC→DONE transition.
- Special cases (1-cycle, no CALC):
  - b=0: DIV/DIVU → all ones; REM/REMU → a.
  - Signed overflow, a=100…0 and b=all ones, DIV → a; REM → 0.
- kill_i in any state: next state IDLE, no done_o pulse, result_o unchanged.
  - kill_i with start_i in the same cycle: kill wins, start dropped.
  - kill_i in the DONE cycle: done_o already asserted is not retracted; a start in that cycle is dropped.
- start_i while busy_o=1: ignored, with no effect on the in-flight op.
- Width rules:
  - Accumulator 2*XLEN bits.
  - Counter $clog2(XLEN) bits, down-counting; no wrap, since termination is at 0.
  - Negation of the most negative value wraps naturally and is required for MULH correctness.

Decomposition:
- Shared defines file (xgriscv_defines.v): XLEN and the MD_* funct3 encodings (MD_MUL … MD_REMU).
- FSM state encodings (IDLE/CALC/DONE) are local localparams.
- One natural sub-module: div_step, a combinational one-bit restoring division step on {remainder, dividend} → {remainder', quotient bit}, instantiated once.

Test Plan:
- XLEN=32, FAST_MUL=0, MUL a=7 b=-3 → done_o exactly 33 cycles after start; result 0xFFFFFFEB; busy_o high 32 cycles; rd_o = rd_i.
- MULH a=0x80000000 b=0x80000000 → 0x40000000; MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE; MULHSU a=-1 b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=-7 b=2 → 0xFFFFFFFD; REM a=-7 b=2 → 0xFFFFFFFF; DIVU a=100 b=7 → 14; REMU → 2.
- DIV a=5 b=0 → 0xFFFFFFFF; REM a=5 b=0 → 5; DIV a=0x80000000 b=-1 → 0x80000000; REM → 0. Each done after 1 cycle, busy_o never high.
- kill_i at cycle 10 of a DIVU → no done_o, IDLE next cycle. start_i+kill_i together → nothing. Reset pulled low mid-CALC → all outputs 0 immediately (asynchronous).
- Back-to-back: start in the DONE cycle of op1 → op2 done 33 cycles later. start during busy → ignored. FAST_MUL=1: MUL 6×7 → 42 one cycle after start.
